// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch stage and its neighbours: opcodes, register
// specifiers, instruction field positions and fetch FSM states.
package instruction_fetch_pkg;

  localparam int unsigned InstWidth = 28;

  // 4-bit opcode space in bits [27:24]
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_STO = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_BLE = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_LED = 4'h5;

  // 8-bit register specifiers used in the dest/src fields
  localparam logic [7:0] REG_R0  = 8'h00;
  localparam logic [7:0] REG_R1  = 8'h01;
  localparam logic [7:0] REG_R2  = 8'h02;
  localparam logic [7:0] REG_R3  = 8'h03;
  localparam logic [7:0] REG_LED = 8'hff;

  localparam int unsigned OPCODE_MSB = 27;
  localparam int unsigned OPCODE_LSB = 24;
  localparam int unsigned DEST_MSB   = 23;
  localparam int unsigned DEST_LSB   = 16;
  localparam int unsigned SRC1_MSB   = 15;
  localparam int unsigned SRC1_LSB   = 8;
  localparam int unsigned SRC0_MSB   = 7;
  localparam int unsigned SRC0_LSB   = 0;

  typedef enum logic [0:0] {
    StHalt,
    StRun
  } fetch_state_e;

  function automatic logic [3:0] opcode_of(input logic [InstWidth-1:0] inst);
    return inst[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, addresses the combinational instruction ROM and
// registers the returned word for decode, handling stalls and branch redirects.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned          ADDR_W   = 16,
  parameter int unsigned          INST_W   = 28,
  parameter int unsigned          TARGET_W = 8,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                iRun,
  input  logic                iStall,
  input  logic                iBranchTaken,
  input  logic [TARGET_W-1:0] iBranchTarget,
  output logic [ADDR_W-1:0]   oAddress,
  input  logic [INST_W-1:0]   iInstruction,
  output logic [INST_W-1:0]   oInstruction,
  output logic [ADDR_W-1:0]   oInstPC,
  output logic                oInstValid,
  output logic                oHalted
);

  fetch_state_e        state_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [ADDR_W-1:0]   target_ext;

  assign target_ext = ADDR_W'(iBranchTarget);
  assign oAddress   = pc_q;
  assign oHalted    = (state_q == StHalt);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q      <= StHalt;
      pc_q         <= RESET_PC;
      oInstruction <= '0;
      oInstPC      <= '0;
      oInstValid   <= 1'b0;
    end else begin
      unique case (state_q)
        StHalt: begin
          // Leaving HALT costs one edge; the first fetch happens on the next one.
          oInstValid <= 1'b0;
          if (iRun) begin
            state_q <= StRun;
          end
        end
        StRun: begin
          if (iBranchTaken) begin
            // Redirect overrides stall; the in-flight wrong-path word is dropped.
            pc_q       <= target_ext;
            oInstValid <= 1'b0;
            if (!iRun) begin
              state_q <= StHalt;
            end
          end else if (!iRun) begin
            state_q    <= StHalt;
            oInstValid <= 1'b0;
          end else if (!iStall) begin
            oInstruction <= iInstruction;
            oInstPC      <= pc_q;
            oInstValid   <= 1'b1;
            pc_q         <= pc_q + ADDR_W'(1);
          end
        end
        default: state_q <= StHalt;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized self-checking bench for instruction_fetch against a cycle-level
// reference model; a second instance starting near the top of memory checks wrap.
module tb_instruction_fetch;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        iRun, iStall, iBranchTaken;
  logic [7:0]  iBranchTarget;
  logic [15:0] oAddress, oInstPC;
  logic [27:0] iInstruction, oInstruction;
  logic        oInstValid, oHalted;

  logic        w_stall, w_branch;
  logic [7:0]  w_target;
  logic [15:0] w_address, w_inst_pc;
  logic [27:0] w_rom, w_inst;
  logic        w_valid, w_halted;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit          m_halted;
  int          m_pc;
  logic [27:0] m_inst;
  int          m_ipc;
  bit          m_valid;

  always #5 Clock = ~Clock;

  function automatic logic [27:0] rom_word(input logic [15:0] a);
    return {a[15:4] ^ 12'hc3a, a};
  endfunction

  assign iInstruction = rom_word(oAddress);
  assign w_rom        = rom_word(w_address);

  instruction_fetch u_dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .iRun          (iRun),
    .iStall        (iStall),
    .iBranchTaken  (iBranchTaken),
    .iBranchTarget (iBranchTarget),
    .oAddress      (oAddress),
    .iInstruction  (iInstruction),
    .oInstruction  (oInstruction),
    .oInstPC       (oInstPC),
    .oInstValid    (oInstValid),
    .oHalted       (oHalted)
  );

  instruction_fetch #(
    .RESET_PC (16'hfffe)
  ) u_wrap (
    .Clock         (Clock),
    .Reset         (Reset),
    .iRun          (iRun),
    .iStall        (w_stall),
    .iBranchTaken  (w_branch),
    .iBranchTarget (w_target),
    .oAddress      (w_address),
    .iInstruction  (w_rom),
    .oInstruction  (w_inst),
    .oInstPC       (w_inst_pc),
    .oInstValid    (w_valid),
    .oHalted       (w_halted)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_halted = 1'b1;
    m_pc     = 0;
    m_inst   = '0;
    m_ipc    = 0;
    m_valid  = 1'b0;
  endtask

  // One clock edge of the fetch rules, using the inputs present at that edge.
  task automatic model_step();
    if (m_halted) begin
      m_valid = 1'b0;
      m_halted = !iRun;
    end else if (iBranchTaken) begin
      m_pc     = int'(iBranchTarget);
      m_valid  = 1'b0;
      m_halted = !iRun;
    end else if (!iRun) begin
      m_halted = 1'b1;
      m_valid  = 1'b0;
    end else if (!iStall) begin
      m_inst  = rom_word(16'(m_pc));
      m_ipc   = m_pc;
      m_valid = 1'b1;
      m_pc    = (m_pc + 1) % 65536;
    end
  endtask

  task automatic check_model();
    check_eq("address", 32'(oAddress), 32'(m_pc));
    check_eq("halted", 32'(oHalted), 32'(m_halted));
    check_eq("valid", 32'(oInstValid), 32'(m_valid));
    if (m_valid) begin
      check_eq("inst", 32'(oInstruction), 32'(m_inst));
      check_eq("inst_pc", 32'(oInstPC), 32'(m_ipc));
    end
  endtask

  // Called at a negedge: apply inputs, take one edge, check at the next negedge.
  task automatic cycle(input bit run, input bit stall, input bit br, input logic [7:0] tgt);
    iRun          = run;
    iStall        = stall;
    iBranchTaken  = br;
    iBranchTarget = tgt;
    @(posedge Clock);
    model_step();
    @(negedge Clock);
    check_model();
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_addr"}, 32'(oAddress), 32'h0);
    check_eq({tag, "_inst"}, 32'(oInstruction), 32'h0);
    check_eq({tag, "_ipc"}, 32'(oInstPC), 32'h0);
    check_eq({tag, "_valid"}, 32'(oInstValid), 32'h0);
    check_eq({tag, "_halted"}, 32'(oHalted), 32'h1);
  endtask

  // Asynchronous pulse placed between clock edges, with hostile inputs applied.
  task automatic async_reset_pulse();
    #($urandom_range(1, 3));
    iRun = 1'b1; iStall = 1'b1; iBranchTaken = 1'b1; iBranchTarget = 8'h77;
    Reset = 1'b1;
    #1;
    check_reset_values("rst_async");
    @(posedge Clock);
    #1;
    check_reset_values("rst_held");
    #($urandom_range(1, 2));
    Reset = 1'b0;
    model_reset();
    @(negedge Clock);
  endtask

  initial begin
    Reset = 1'b1;
    iRun = 1'b0; iStall = 1'b0; iBranchTaken = 1'b0; iBranchTarget = '0;
    w_stall = 1'b0; w_branch = 1'b0; w_target = '0;
    model_reset();
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    check_reset_values("reset");
    check_eq("wrap_reset_addr", 32'(w_address), 32'hfffe);

    // HALT -> RUN, no fetch on that edge
    cycle(1, 0, 0, 8'h0);
    check_eq("start_valid", 32'(oInstValid), 32'h0);
    check_eq("start_addr", 32'(oAddress), 32'h0);
    check_eq("wrap_start_valid", 32'(w_valid), 32'h0);

    cycle(1, 0, 0, 8'h0);
    check_eq("fetch0_ipc", 32'(oInstPC), 32'h0);
    check_eq("fetch0_addr", 32'(oAddress), 32'h1);
    check_eq("wrap_ipc0", 32'(w_inst_pc), 32'hfffe);
    cycle(1, 0, 0, 8'h0);
    check_eq("fetch1_ipc", 32'(oInstPC), 32'h1);
    check_eq("wrap_ipc1", 32'(w_inst_pc), 32'hffff);
    cycle(1, 0, 0, 8'h0);
    check_eq("fetch2_ipc", 32'(oInstPC), 32'h2);
    check_eq("wrap_ipc2", 32'(w_inst_pc), 32'h0);
    check_eq("wrap_valid", 32'(w_valid), 32'h1);
    check_eq("wrap_inst", 32'(w_inst), 32'(rom_word(16'h0000)));

    cycle(1, 0, 0, 8'h0);
    cycle(1, 0, 0, 8'h0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 1, 0, 8'h0);
      check_eq("stall_ipc", 32'(oInstPC), 32'h4);
      check_eq("stall_addr", 32'(oAddress), 32'h5);
      check_eq("stall_valid", 32'(oInstValid), 32'h1);
    end
    cycle(1, 0, 0, 8'h0);
    check_eq("unstall_ipc", 32'(oInstPC), 32'h5);

    repeat (4) cycle(1, 0, 0, 8'h0);
    check_eq("pre_branch_addr", 32'(oAddress), 32'd10);
    cycle(1, 0, 1, 8'd8);
    check_eq("branch_valid", 32'(oInstValid), 32'h0);
    check_eq("branch_addr", 32'(oAddress), 32'd8);
    cycle(1, 0, 0, 8'h0);
    check_eq("target_ipc", 32'(oInstPC), 32'd8);
    check_eq("target_valid", 32'(oInstValid), 32'h1);

    cycle(1, 1, 1, 8'd2);
    check_eq("br_stall_addr", 32'(oAddress), 32'd2);
    check_eq("br_stall_valid", 32'(oInstValid), 32'h0);

    // Branch while stopping: resume begins at the target
    cycle(0, 0, 1, 8'h40);
    check_eq("br_halt_halted", 32'(oHalted), 32'h1);
    cycle(1, 0, 0, 8'h0);
    cycle(1, 0, 0, 8'h0);
    check_eq("resume_ipc", 32'(oInstPC), 32'h40);

    async_reset_pulse();
    cycle(1, 0, 0, 8'h0);
    cycle(1, 0, 0, 8'h0);
    check_eq("restart_ipc", 32'(oInstPC), 32'h0);

    for (int n = 0; n < 1500; n++) begin
      if (n % 373 == 200) begin
        async_reset_pulse();
      end else begin
        cycle(($urandom_range(0, 9) != 0), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 7) == 0), 8'($urandom));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
